scale_index_gen: RTL and testbench

Parametrised nearest-neighbour address generator for the image-scaling datapath. It accepts source and target frame dimensions and computes fixed-point X and Y scale steps with an internal sequential divider. It then streams one source coordinate pair per target pixel, in raster order, over a valid/ready handshake. It replaces the single-axis, fixed-×100 scale path with a two-axis, configurable-precision generator that supports backpressure and error reporting.

---
 rtl/scale_index_gen.sv | 332 +++++++++++++++++++++++++++++++++
 tb/tb_scale_index_gen.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scale_index_gen.sv
// -----------------------------------------------------------------------------
// scale_index_gen
//
// Nearest-neighbour address generator for the image-scaling datapath.
// On an accepted start it latches the source and target frame dimensions.
// It then computes fixed-point X and Y scale steps with one shared restoring
// divider. After that it streams one source coordinate pair per target pixel,
// in raster order, over a valid/ready handshake.
//
// Parameters
//   W     width of every dimension and coordinate
//   FRAC  fractional bits of the scale steps and accumulators
//
// Ports
//   clk_i          clock, everything on the rising edge
//   reset_i        synchronous active-high reset
//   start_i        one-cycle request, sampled only in IDLE
//   sw_i, sh_i     source width / height
//   tw_i, th_i     target width / height
//   busy_o         frame in progress (divide or stream)
//   done_o         one-cycle pulse after the last coordinate handshake
//   err_o          one-cycle pulse when a start carries a zero dimension
//   idx_valid_o    coordinate output valid
//   idx_ready_i    downstream accept
//   src_x_o/src_y_o  source pixel coordinate
//   dst_x_o/dst_y_o  target pixel coordinate being emitted
//   last_col_o     dst_x == tw-1
//   last_frame_o   dst_x == tw-1 and dst_y == th-1
// -----------------------------------------------------------------------------
module scale_index_gen #(
   parameter int W    = 16,
   parameter int FRAC = 8
) (
   input  logic         clk_i,
   input  logic         reset_i,
   input  logic         start_i,
   input  logic [W-1:0] sw_i,
   input  logic [W-1:0] sh_i,
   input  logic [W-1:0] tw_i,
   input  logic [W-1:0] th_i,
   output logic         busy_o,
   output logic         done_o,
   output logic         err_o,
   output logic         idx_valid_o,
   input  logic         idx_ready_i,
   output logic [W-1:0] src_x_o,
   output logic [W-1:0] src_y_o,
   output logic [W-1:0] dst_x_o,
   output logic [W-1:0] dst_y_o,
   output logic         last_col_o,
   output logic         last_frame_o
);

   localparam int             DW        = W + FRAC;
   localparam int             CW        = $clog2(DW);
   localparam logic [CW-1:0]  DIV_LAST  = CW'(DW - 1);
   localparam logic [W-1:0]   ONE_W     = W'(1);
   localparam logic [FRAC-1:0] FRAC_ZERO = '0;

   typedef enum logic [2:0] {
      IDLE,
      DIV_X,
      DIV_Y,
      RUN,
      FIN
   } state_t;

   state_t         state_q, state_d;

   logic [W-1:0]   swLat_q, swLat_d;
   logic [W-1:0]   shLat_q, shLat_d;
   logic [W-1:0]   twLat_q, twLat_d;
   logic [W-1:0]   thLat_q, thLat_d;

   logic [DW-1:0]  divData_q, divData_d;
   logic [W:0]     divRem_q, divRem_d;
   logic [CW-1:0]  divCnt_q, divCnt_d;

   logic [DW-1:0]  stepX_q, stepX_d;
   logic [DW-1:0]  stepY_q, stepY_d;
   logic [DW-1:0]  accX_q, accX_d;
   logic [DW-1:0]  accY_q, accY_d;

   logic [W-1:0]   dstX_q, dstX_d;
   logic [W-1:0]   dstY_q, dstY_d;
   logic [W-1:0]   srcX_q, srcX_d;
   logic [W-1:0]   srcY_q, srcY_d;
   logic           lastCol_q, lastCol_d;
   logic           lastFrame_q, lastFrame_d;
   logic           idxValid_q, idxValid_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic           err_q, err_d;

   logic [W:0]     divisor;
   logic [W:0]     remShift;
   logic           quotBit;
   logic [W:0]     remNext;
   logic [DW-1:0]  quotNext;

   logic [DW-1:0]  accXInc;
   logic [DW-1:0]  accYInc;
   logic [W-1:0]   dstXInc;
   logic [W-1:0]   dstYInc;
   logic [W-1:0]   srcXInc;
   logic [W-1:0]   srcYInc;
   logic           anyZero;
   logic           handshake;

   // Integer part of an accumulator, clamped to the last valid source pixel.
   function automatic logic [W-1:0] clampCoord(input logic [DW-1:0] acc,
                                               input logic [W-1:0]  dim);
      logic [W-1:0] whole;
      logic [W-1:0] result;
      whole = acc[DW-1:FRAC];
      if (whole > dim - ONE_W) begin
         result = dim - ONE_W;
      end else begin
         result = whole;
      end
      return result;
   endfunction

   // One restoring-division step. divData holds the not-yet-consumed dividend
   // bits at the top and the quotient bits resolved so far at the bottom, so
   // after DW steps it holds the full quotient. The remainder needs one extra
   // bit because it is shifted before the trial subtraction.
   always_comb begin
      divisor  = (state_q == DIV_Y) ? {1'b0, thLat_q} : {1'b0, twLat_q};
      remShift = {divRem_q[W-1:0], divData_q[DW-1]};
      quotBit  = (remShift >= divisor);
      remNext  = quotBit ? (remShift - divisor) : remShift;
      quotNext = {divData_q[DW-2:0], quotBit};
   end

   // Candidate values for the next coordinate, along the row and across rows.
   // They are precomputed so that the row wrap costs no extra cycle.
   always_comb begin
      accXInc   = accX_q + stepX_q;
      accYInc   = accY_q + stepY_q;
      dstXInc   = dstX_q + ONE_W;
      dstYInc   = dstY_q + ONE_W;
      srcXInc   = clampCoord(accXInc, swLat_q);
      srcYInc   = clampCoord(accYInc, shLat_q);
      anyZero   = (sw_i == '0) || (sh_i == '0) || (tw_i == '0) || (th_i == '0);
      handshake = idxValid_q && idx_ready_i;
   end

   // Next-state and output logic. Every register holds its value by default.
   // done and err are pulses, so they default to 0.
   always_comb begin
      state_d     = state_q;
      swLat_d     = swLat_q;
      shLat_d     = shLat_q;
      twLat_d     = twLat_q;
      thLat_d     = thLat_q;
      divData_d   = divData_q;
      divRem_d    = divRem_q;
      divCnt_d    = divCnt_q;
      stepX_d     = stepX_q;
      stepY_d     = stepY_q;
      accX_d      = accX_q;
      accY_d      = accY_q;
      dstX_d      = dstX_q;
      dstY_d      = dstY_q;
      srcX_d      = srcX_q;
      srcY_d      = srcY_q;
      lastCol_d   = lastCol_q;
      lastFrame_d = lastFrame_q;
      idxValid_d  = idxValid_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      err_d       = 1'b0;

      case (state_q)
         IDLE: begin
            if (start_i) begin
               swLat_d = sw_i;
               shLat_d = sh_i;
               twLat_d = tw_i;
               thLat_d = th_i;
               if (anyZero) begin
                  err_d = 1'b1;
               end else begin
                  divData_d = {sw_i, FRAC_ZERO};
                  divRem_d  = '0;
                  divCnt_d  = '0;
                  busy_d    = 1'b1;
                  state_d   = DIV_X;
               end
            end
         end

         DIV_X: begin
            divData_d = quotNext;
            divRem_d  = remNext;
            divCnt_d  = divCnt_q + 1'b1;
            if (divCnt_q == DIV_LAST) begin
               stepX_d   = quotNext;
               divData_d = {shLat_q, FRAC_ZERO};
               divRem_d  = '0;
               divCnt_d  = '0;
               state_d   = DIV_Y;
            end
         end

         DIV_Y: begin
            divData_d = quotNext;
            divRem_d  = remNext;
            divCnt_d  = divCnt_q + 1'b1;
            if (divCnt_q == DIV_LAST) begin
               stepY_d     = quotNext;
               accX_d      = '0;
               accY_d      = '0;
               dstX_d      = '0;
               dstY_d      = '0;
               srcX_d      = '0;
               srcY_d      = '0;
               lastCol_d   = (twLat_q == ONE_W);
               lastFrame_d = (twLat_q == ONE_W) && (thLat_q == ONE_W);
               idxValid_d  = 1'b1;
               state_d     = RUN;
            end
         end

         RUN: begin
            if (handshake) begin
               if (!lastCol_q) begin
                  dstX_d      = dstXInc;
                  accX_d      = accXInc;
                  srcX_d      = srcXInc;
                  lastCol_d   = (dstXInc == twLat_q - ONE_W);
                  lastFrame_d = (dstXInc == twLat_q - ONE_W) &&
                                (dstY_q == thLat_q - ONE_W);
               end else if (!lastFrame_q) begin
                  dstX_d      = '0;
                  accX_d      = '0;
                  srcX_d      = '0;
                  dstY_d      = dstYInc;
                  accY_d      = accYInc;
                  srcY_d      = srcYInc;
                  lastCol_d   = (twLat_q == ONE_W);
                  lastFrame_d = (twLat_q == ONE_W) &&
                                (dstYInc == thLat_q - ONE_W);
               end else begin
                  dstX_d      = '0;
                  dstY_d      = '0;
                  srcX_d      = '0;
                  srcY_d      = '0;
                  lastCol_d   = 1'b0;
                  lastFrame_d = 1'b0;
                  idxValid_d  = 1'b0;
                  busy_d      = 1'b0;
                  done_d      = 1'b1;
                  state_d     = FIN;
               end
            end
         end

         FIN: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register. Reset discards any frame in flight and zeroes every output.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= IDLE;
         swLat_q     <= '0;
         shLat_q     <= '0;
         twLat_q     <= '0;
         thLat_q     <= '0;
         divData_q   <= '0;
         divRem_q    <= '0;
         divCnt_q    <= '0;
         stepX_q     <= '0;
         stepY_q     <= '0;
         accX_q      <= '0;
         accY_q      <= '0;
         dstX_q      <= '0;
         dstY_q      <= '0;
         srcX_q      <= '0;
         srcY_q      <= '0;
         lastCol_q   <= 1'b0;
         lastFrame_q <= 1'b0;
         idxValid_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         swLat_q     <= swLat_d;
         shLat_q     <= shLat_d;
         twLat_q     <= twLat_d;
         thLat_q     <= thLat_d;
         divData_q   <= divData_d;
         divRem_q    <= divRem_d;
         divCnt_q    <= divCnt_d;
         stepX_q     <= stepX_d;
         stepY_q     <= stepY_d;
         accX_q      <= accX_d;
         accY_q      <= accY_d;
         dstX_q      <= dstX_d;
         dstY_q      <= dstY_d;
         srcX_q      <= srcX_d;
         srcY_q      <= srcY_d;
         lastCol_q   <= lastCol_d;
         lastFrame_q <= lastFrame_d;
         idxValid_q  <= idxValid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign err_o        = err_q;
   assign idx_valid_o  = idxValid_q;
   assign src_x_o      = srcX_q;
   assign src_y_o      = srcY_q;
   assign dst_x_o      = dstX_q;
   assign dst_y_o      = dstY_q;
   assign last_col_o   = lastCol_q;
   assign last_frame_o = lastFrame_q;

endmodule

// File: tb/tb_scale_index_gen.sv
// -----------------------------------------------------------------------------
// tb_scale_index_gen
//
// Self-checking bench for scale_index_gen. Every frame is compared against a
// list of expected coordinates built from the scaling rule:
//   src = min(floor(i * floor(s * 2^FRAC / t) / 2^FRAC), s - 1)
// The bench also covers reset, the error pulse, backpressure holding,
// mid-operation reset and randomised frames.
// -----------------------------------------------------------------------------
module tb_scale_index_gen;

   localparam int W    = 16;
   localparam int FRAC = 8;
   localparam int DW   = W + FRAC;

   typedef struct {
      logic [W-1:0] sx;
      logic [W-1:0] sy;
      logic [W-1:0] dx;
      logic [W-1:0] dy;
      logic         lc;
      logic         lf;
   } coord_t;

   logic         clk = 1'b0;
   logic         reset_i;
   logic         start_i;
   logic [W-1:0] sw_i, sh_i, tw_i, th_i;
   logic         busy_o, done_o, err_o, idx_valid_o;
   logic         idx_ready_i;
   logic [W-1:0] src_x_o, src_y_o, dst_x_o, dst_y_o;
   logic         last_col_o, last_frame_o;

   int           checks = 0;
   int           errors = 0;
   coord_t       expQ[$];

   always #5 clk = ~clk;

   scale_index_gen #(.W(W), .FRAC(FRAC)) dut (
      .clk_i        (clk),
      .reset_i      (reset_i),
      .start_i      (start_i),
      .sw_i         (sw_i),
      .sh_i         (sh_i),
      .tw_i         (tw_i),
      .th_i         (th_i),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .err_o        (err_o),
      .idx_valid_o  (idx_valid_o),
      .idx_ready_i  (idx_ready_i),
      .src_x_o      (src_x_o),
      .src_y_o      (src_y_o),
      .dst_x_o      (dst_x_o),
      .dst_y_o      (dst_y_o),
      .last_col_o   (last_col_o),
      .last_frame_o (last_frame_o)
   );

   // Single comparison point: counts the check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Advance one clock and settle just after the rising edge.
   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   // Expected coordinate stream, from the scaling rule in plain arithmetic.
   task automatic buildModel(input int sw, input int sh, input int tw, input int th);
      longint stepX, stepY, sx, sy;
      coord_t e;
      expQ.delete();
      stepX = (longint'(sw) << FRAC) / tw;
      stepY = (longint'(sh) << FRAC) / th;
      for (int y = 0; y < th; y++) begin
         for (int x = 0; x < tw; x++) begin
            sx = (longint'(x) * stepX) >> FRAC;
            sy = (longint'(y) * stepY) >> FRAC;
            if (sx > sw - 1) sx = sw - 1;
            if (sy > sh - 1) sy = sh - 1;
            e.sx = W'(sx);
            e.sy = W'(sy);
            e.dx = W'(x);
            e.dy = W'(y);
            e.lc = (x == tw - 1);
            e.lf = (x == tw - 1) && (y == th - 1);
            expQ.push_back(e);
         end
      end
   endtask

   task automatic issueStart(input int sw, input int sh, input int tw, input int th);
      start_i = 1'b1;
      sw_i    = W'(sw);
      sh_i    = W'(sh);
      tw_i    = W'(tw);
      th_i    = W'(th);
      stepCycle();
      start_i = 1'b0;
      sw_i    = W'($urandom);
      sh_i    = W'($urandom);
      tw_i    = W'($urandom);
      th_i    = W'($urandom);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_flags"},
                  64'({busy_o, done_o, err_o, idx_valid_o, last_col_o, last_frame_o}),
                  64'(0));
      checkOutput({tag, "_coord"}, {src_x_o, src_y_o, dst_x_o, dst_y_o}, 64'(0));
   endtask

   // Run one full frame with idx_ready high readyPct percent of the time.
   // Checks the latency, every coordinate, stall holding and the done pulse.
   task automatic applyStimulus(input int sw, input int sh, input int tw, input int th,
                                input int readyPct, input bit tryLateStart);
      int           edges, hs, cyc, total;
      bit           stalled;
      logic [63:0]  heldCoord;
      logic [1:0]   heldFlags;
      coord_t       e;
      buildModel(sw, sh, tw, th);
      total       = tw * th;
      idx_ready_i = 1'b0;
      issueStart(sw, sh, tw, th);
      checkOutput("busy_after_start", 64'(busy_o), 64'(1));
      edges = 0;
      while (!idx_valid_o && edges < 500) begin
         stepCycle();
         edges++;
      end
      checkOutput("first_valid_latency", 64'(edges), 64'(2 * DW));
      hs        = 0;
      cyc       = 0;
      stalled   = 1'b0;
      heldCoord = '0;
      heldFlags = '0;
      while (hs < total && cyc < 20000) begin
         idx_ready_i = ($urandom_range(99) < readyPct);
         if (stalled) begin
            checkOutput("hold_valid", 64'(idx_valid_o), 64'(1));
            checkOutput("hold_coord", {src_x_o, src_y_o, dst_x_o, dst_y_o}, heldCoord);
            checkOutput("hold_flags", 64'({last_col_o, last_frame_o}), 64'(heldFlags));
         end
         if (idx_valid_o && idx_ready_i) begin
            e = expQ.pop_front();
            checkOutput("coord", {src_x_o, src_y_o, dst_x_o, dst_y_o},
                        {e.sx, e.sy, e.dx, e.dy});
            checkOutput("last_flags", 64'({last_col_o, last_frame_o}), 64'({e.lc, e.lf}));
            hs++;
            stalled = 1'b0;
         end else if (idx_valid_o) begin
            stalled   = 1'b1;
            heldCoord = {src_x_o, src_y_o, dst_x_o, dst_y_o};
            heldFlags = {last_col_o, last_frame_o};
         end else begin
            stalled = 1'b0;
         end
         stepCycle();
         cyc++;
      end
      idx_ready_i = 1'b0;
      checkOutput("handshake_count", 64'(hs), 64'(total));
      checkOutput("done_pulse", 64'(done_o), 64'(1));
      checkOutput("busy_in_fin", 64'(busy_o), 64'(0));
      checkOutput("valid_after_last", 64'(idx_valid_o), 64'(0));
      if (tryLateStart) begin
         start_i = 1'b1;
         sw_i    = W'(3);
         sh_i    = W'(3);
         tw_i    = W'(3);
         th_i    = W'(3);
      end
      stepCycle();
      start_i = 1'b0;
      checkOutput("done_cleared", 64'(done_o), 64'(0));
      checkOutput("idle_busy", 64'(busy_o), 64'(0));
   endtask

   // Watch a quiet interval: nothing may pulse or become valid.
   task automatic checkQuiet(input string tag, input int cycles);
      bit noise;
      noise = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         if (done_o || idx_valid_o || busy_o || err_o) noise = 1'b1;
         stepCycle();
      end
      checkOutput(tag, 64'(noise), 64'(0));
   endtask

   initial begin
      bit found;
      int guard;
      reset_i     = 1'b1;
      start_i     = 1'b0;
      idx_ready_i = 1'b0;
      sw_i        = '0;
      sh_i        = '0;
      tw_i        = '0;
      th_i        = '0;
      repeat (3) stepCycle();
      checkAllZero("reset_state");
      reset_i = 1'b0;
      stepCycle();

      $display("[TB] upscale 4x2 -> 8x2");
      applyStimulus(4, 2, 8, 2, 100, 1'b1);

      $display("[TB] downscale 10x1 -> 3x1");
      applyStimulus(10, 1, 3, 1, 100, 1'b0);

      $display("[TB] identity 5x3");
      applyStimulus(5, 3, 5, 3, 100, 1'b0);

      $display("[TB] upscale with backpressure");
      applyStimulus(4, 2, 8, 2, 50, 1'b0);

      $display("[TB] zero target width");
      start_i = 1'b1;
      sw_i    = W'(4);
      sh_i    = W'(2);
      tw_i    = W'(0);
      th_i    = W'(2);
      stepCycle();
      start_i = 1'b0;
      checkOutput("err_pulse", 64'(err_o), 64'(1));
      checkOutput("err_busy", 64'(busy_o), 64'(0));
      checkOutput("err_valid", 64'(idx_valid_o), 64'(0));
      stepCycle();
      checkOutput("err_cleared", 64'(err_o), 64'(0));
      checkQuiet("err_quiet", 60);
      applyStimulus(4, 2, 8, 2, 100, 1'b0);

      $display("[TB] reset during DIV_Y");
      issueStart(4, 2, 8, 2);
      repeat (DW + 4) stepCycle();
      reset_i = 1'b1;
      stepCycle();
      reset_i = 1'b0;
      checkAllZero("reset_divy");
      checkQuiet("divy_quiet", 60);
      applyStimulus(4, 2, 8, 2, 100, 1'b0);

      $display("[TB] reset during RUN");
      issueStart(4, 2, 8, 2);
      idx_ready_i = 1'b1;
      found       = 1'b0;
      guard       = 0;
      while (!found && guard < 200) begin
         if (idx_valid_o && dst_x_o == W'(3)) begin
            found = 1'b1;
         end else begin
            stepCycle();
            guard++;
         end
      end
      checkOutput("reached_dst3", 64'(found), 64'(1));
      reset_i = 1'b1;
      stepCycle();
      reset_i     = 1'b0;
      idx_ready_i = 1'b0;
      checkAllZero("reset_run");
      checkQuiet("run_quiet", 60);
      applyStimulus(4, 2, 8, 2, 100, 1'b0);

      $display("[TB] randomised frames");
      for (int n = 0; n < 6; n++) begin
         applyStimulus(int'($urandom_range(40, 1)), int'($urandom_range(20, 1)),
                       int'($urandom_range(8, 1)), int'($urandom_range(5, 1)),
                       int'($urandom_range(100, 30)), 1'($urandom_range(1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
